// File: rtl/shift_pkg.sv
// Shared opcode encoding and datapath width for the shift stage.
package shift_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    SHIFT_SLL = 3'b000,
    SHIFT_SRL = 3'b001,
    SHIFT_SRA = 3'b010,
    SHIFT_ROL = 3'b011,
    SHIFT_ROR = 3'b100
  } shift_op_e;

endpackage

// File: rtl/bit_rev32.sv
// Combinational bit reversal, so left shifts/rotates can reuse the right-shift core.
module bit_rev32
  import shift_pkg::*;
(
  input  logic [XLEN-1:0] i_d,
  output logic [XLEN-1:0] o_d
);

  for (genvar i = 0; i < XLEN; i++) begin : g_rev
    assign o_d[i] = i_d[XLEN-1-i];
  end

endmodule

// File: rtl/shift_stage.sv
// Two-stage shift/rotate pipeline with valid/ready handshake on both ports.
// Rotates (ROL/ROR) exist only when SHIFT_STAGE_ROT_EN is defined; otherwise they decode as reserved.
module shift_stage
  import shift_pkg::*;
#(
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal
);

  logic            r_s1_valid;
  logic [XLEN-1:0] r_s1_a;
  logic [4:0]      r_s1_shamt;
  logic [RD_W-1:0] r_s1_rd;
  logic            r_s1_illegal;
  logic            r_s1_rev;
  logic            r_s1_fill;
`ifdef SHIFT_STAGE_ROT_EN
  logic            r_s1_rot;
  logic            w_rot;
`endif

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_data;
  logic [RD_W-1:0] r_out_rd;
  logic            r_out_illegal;

  logic            w_s2_adv;
  logic            w_s1_adv;
  logic            w_legal;
  logic            w_rev;
  logic            w_sra;
  logic [XLEN-1:0] w_a_rev;
  logic [XLEN-1:0] w_res_rev;
  logic [XLEN-1:0] w_lvl [0:5];
  logic            w_unused_b;

  assign w_unused_b = ^in_b[XLEN-1:5];

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  always_comb begin
    w_legal = 1'b0;
    w_rev   = 1'b0;
    w_sra   = 1'b0;
`ifdef SHIFT_STAGE_ROT_EN
    w_rot   = 1'b0;
`endif
    case (in_op)
      SHIFT_SLL: begin w_legal = 1'b1; w_rev = 1'b1; end
      SHIFT_SRL: w_legal = 1'b1;
      SHIFT_SRA: begin w_legal = 1'b1; w_sra = 1'b1; end
`ifdef SHIFT_STAGE_ROT_EN
      SHIFT_ROL: begin w_legal = 1'b1; w_rev = 1'b1; w_rot = 1'b1; end
      SHIFT_ROR: begin w_legal = 1'b1; w_rot = 1'b1; end
`endif
      default: ;
    endcase
  end

  bit_rev32 u_rev_s1 (.i_d(in_a),     .o_d(w_a_rev));
  bit_rev32 u_rev_s2 (.i_d(w_lvl[5]), .o_d(w_res_rev));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_shamt   <= '0;
      r_s1_rd      <= '0;
      r_s1_illegal <= 1'b0;
      r_s1_rev     <= 1'b0;
      r_s1_fill    <= 1'b0;
`ifdef SHIFT_STAGE_ROT_EN
      r_s1_rot     <= 1'b0;
`endif
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a       <= !w_legal ? '0 : (w_rev ? w_a_rev : in_a);
        r_s1_shamt   <= in_b[4:0];
        r_s1_rd      <= in_rd;
        r_s1_illegal <= !w_legal;
        r_s1_rev     <= w_rev;
        r_s1_fill    <= w_sra & in_a[XLEN-1];
`ifdef SHIFT_STAGE_ROT_EN
        r_s1_rot     <= w_rot;
`endif
      end
    end
  end

  // Logarithmic right barrel: level k moves by 2^k, fill bit is 0 or the SRA sign.
  assign w_lvl[0] = r_s1_a;
  for (genvar k = 0; k < 5; k++) begin : g_lvl
    localparam int SH = 1 << k;
`ifdef SHIFT_STAGE_ROT_EN
    assign w_lvl[k+1] = !r_s1_shamt[k] ? w_lvl[k] :
                        r_s1_rot ? {w_lvl[k][SH-1:0], w_lvl[k][XLEN-1:SH]} :
                                   {{SH{r_s1_fill}}, w_lvl[k][XLEN-1:SH]};
`else
    assign w_lvl[k+1] = !r_s1_shamt[k] ? w_lvl[k] :
                                   {{SH{r_s1_fill}}, w_lvl[k][XLEN-1:SH]};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_rd      <= '0;
      r_out_illegal <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data    <= r_s1_illegal ? '0 : (r_s1_rev ? w_res_rev : w_lvl[5]);
        r_out_rd      <= r_s1_rd;
        r_out_illegal <= r_s1_illegal;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_rd      = r_out_rd;
  assign out_illegal = r_out_illegal;

endmodule

// File: tb/tb_shift_stage.sv
// Self-checking bench for shift_stage: arithmetic reference model, scoreboard and directed corner cases.
module tb_shift_stage;
  import shift_pkg::*;

  localparam int RD_W = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_op = 3'd0;
  logic [31:0]     in_a = 32'd0;
  logic [31:0]     in_b = 32'd0;
  logic [RD_W-1:0] in_rd = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_data;
  logic [RD_W-1:0] out_rd;
  logic            out_illegal;

  shift_stage #(.RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]     data;
    logic [RD_W-1:0] rd;
    logic            ill;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [RD_W-1:0] rd);
    exp_t        e;
    int unsigned s;
    s      = 32'(b[4:0]);
    e.rd   = rd;
    e.ill  = 1'b0;
    e.data = 32'd0;
    case (op)
      3'd0: e.data = a << s;
      3'd1: e.data = a >> s;
      3'd2: e.data = 32'($signed(a) >>> s);
`ifdef SHIFT_STAGE_ROT_EN
      3'd3: e.data = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      3'd4: e.data = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every output transfer must match the oldest accepted op; stalls must hold outputs.
  logic prev_stall = 1'b0;
  exp_t prev_out;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, prev_out.data);
        check("stall_rd", 32'(out_rd), 32'(prev_out.rd));
        check("stall_ill", 32'(out_illegal), 32'(prev_out.ill));
      end
      if (out_ready || !out_valid) check("in_ready_rule", 32'(in_ready), 32'd1);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else if (out_ready) begin
          exp_t e;
          e = q.pop_front();
          check("sb_data", out_data, e.data);
          check("sb_rd", 32'(out_rd), 32'(e.rd));
          check("sb_ill", 32'(out_illegal), 32'(e.ill));
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_op, in_a, in_b, in_rd));
      prev_stall = out_valid && !out_ready;
      prev_out   = '{data: out_data, rd: out_rd, ill: out_illegal};
    end
  end

  task automatic send_one(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [RD_W-1:0] rd,
                          input logic [31:0] exp_data, input logic exp_ill);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"}, out_data, exp_data);
    check({name, "_rd"}, 32'(out_rd), 32'(rd));
    check({name, "_ill"}, 32'(out_illegal), 32'(exp_ill));
  endtask

  initial begin
    exp_t e;
    bit   pat [4];
    bit   acc;
    bit   need_new;
    int   sent;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_rd", 32'(out_rd), 32'd0);
    check("rst_ill", 32'(out_illegal), 32'd0);

    e = model(3'd0, 32'h0000_0001, 32'd31, '0);
    check("model_sll", e.data, 32'h8000_0000);
    e = model(3'd2, 32'h8000_0000, 32'd4, '0);
    check("model_sra", e.data, 32'hF800_0000);
    e = model(3'd1, 32'h8000_0000, 32'd4, '0);
    check("model_srl", e.data, 32'h0800_0000);
    e = model(3'd4, 32'h0000_00F1, 32'd4, '0);
`ifdef SHIFT_STAGE_ROT_EN
    check("model_ror", e.data, 32'h1000_000F);
`else
    check("model_ror_ill", 32'(e.ill), 32'd1);
`endif

    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    send_one("sll31", SHIFT_SLL, 32'h0000_0001, 32'd31, 5'd3, 32'h8000_0000, 1'b0);
    send_one("sra4", SHIFT_SRA, 32'h8000_0000, 32'd4, 5'd4, 32'hF800_0000, 1'b0);
    send_one("srl4", SHIFT_SRL, 32'h8000_0000, 32'd4, 5'd5, 32'h0800_0000, 1'b0);
    send_one("sra_sh0", SHIFT_SRA, 32'h8000_1234, 32'd32, 5'd6, 32'h8000_1234, 1'b0);
`ifdef SHIFT_STAGE_ROT_EN
    send_one("ror4", SHIFT_ROR, 32'h0000_00F1, 32'd4, 5'd9, 32'h1000_000F, 1'b0);
    send_one("rol1", SHIFT_ROL, 32'h8000_0001, 32'd1, 5'd10, 32'h0000_0003, 1'b0);
`else
    send_one("ror4", SHIFT_ROR, 32'h0000_00F1, 32'd4, 5'd9, 32'h0000_0000, 1'b1);
    send_one("rol1", SHIFT_ROL, 32'h8000_0001, 32'd1, 5'd10, 32'h0000_0000, 1'b1);
`endif
    send_one("op111", 3'b111, 32'hDEAD_BEEF, 32'd3, 5'd7, 32'h0000_0000, 1'b1);

    // Eight back-to-back ops against a 1,0,0,1 out_ready pattern.
    @(posedge clk); #1;
    sent = 0;
    need_new = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin sent++; need_new = 1'b1; end
      out_ready = pat[c % 4];
      if (sent < 8) begin
        in_valid = 1'b1;
        if (need_new) begin
          in_op = 3'($urandom_range(0, 4));
          in_a  = $urandom;
          in_b  = $urandom;
          in_rd = RD_W'(sent);
          need_new = 1'b0;
        end
      end else begin
        in_valid = 1'b0;
      end
      if (sent == 8 && q.size() == 0 && !out_valid) break;
    end
    check("b2b_sent", 32'(sent), 32'd8);
    check("b2b_drained", 32'(q.size()), 32'd0);

    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_a      = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      in_b      = $urandom;
      if ($urandom_range(0, 7) == 0) in_b[4:0] = 5'd0;
      if ($urandom_range(0, 7) == 0) in_b[4:0] = 5'd31;
      in_rd     = RD_W'($urandom);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && !out_valid) break;
    end
    check("rand_drained", 32'(q.size()), 32'd0);

    // Reset with two ops in flight.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_op = SHIFT_SRL; in_a = 32'hFFFF_0000; in_b = 32'd8; in_rd = 5'd1;
    @(posedge clk); #1;
    in_rd = 5'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", out_data, 32'd0);
    check("midrst_rd", 32'(out_rd), 32'd0);
    check("midrst_ill", 32'(out_illegal), 32'd0);
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("post_rst_no_out", 32'(out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
